// File: rtl/seq_left_shift.sv
// Multi-cycle left shifter: shifts A by B[4:0], at most SHIFT_STEP bits per clock.
// Optional rotate mode is enabled by defining SEQ_SHL_ROTATE_EN.
module seq_left_shift #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef SEQ_SHL_ROTATE_EN
  input  logic        rotate,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state, state_next;
  logic [31:0] sh;
  logic [31:0] sh_shifted;
  logic [4:0]  cnt;
  logic [4:0]  k;
  logic        accept;
  logic        unused_b;

  assign unused_b = ^B[31:5];
  assign accept   = ready && start;

`ifdef SEQ_SHL_ROTATE_EN
  logic rot;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (B[4:0] == 5'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        ready = 1'b0;
        if (cnt == k) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = (B[4:0] == 5'd0) ? DONE : SHIFT;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // k never exceeds the remaining count, so the final step lands exactly on zero
  always_comb begin
    k = (cnt < STEP) ? cnt : STEP;
`ifdef SEQ_SHL_ROTATE_EN
    if (rot) sh_shifted = (sh << k) | (sh >> (6'd32 - {1'b0, k}));
    else     sh_shifted = sh << k;
`else
    sh_shifted = sh << k;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= 32'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
`ifdef SEQ_SHL_ROTATE_EN
      rot    <= 1'b0;
`endif
    end else if (accept) begin
      sh  <= A;
      cnt <= B[4:0];
`ifdef SEQ_SHL_ROTATE_EN
      rot <= rotate;
`endif
      if (B[4:0] == 5'd0) result <= A;
    end else if (state == SHIFT) begin
      sh  <= sh_shifted;
      cnt <= cnt - k;
      if (cnt == k) result <= sh_shifted;
    end
  end

endmodule
